// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with private HI/LO for the E stage.
// The result is computed at issue, parked in pend, and committed when the latency counter expires.
module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mdu_op_d,
  input  logic [3:0]       mdu_op_e,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             stall_mdu
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  pendHi_q, pendHi_d, pendLo_q, pendLo_d;

  logic [2*WIDTH-1:0] extSignedA, extSignedB, extUnsA, extUnsB;
  logic [2*WIDTH-1:0] prodSigned, prodUnsigned, hiLo;
  logic               negA, negB, divZero;
  logic [WIDTH-1:0]   magA, magB, magQuot, magRem;
  logic [WIDTH-1:0]   sQuot, sRem, uQuot, uRem;
  logic               isMulOp, isDivOp, isStartE, isMduD;

  // Full-width products; modulo-2^(2W) wrap makes the signed product exact in two's complement.
  assign extSignedA   = {{WIDTH{data1[WIDTH-1]}}, data1};
  assign extSignedB   = {{WIDTH{data2[WIDTH-1]}}, data2};
  assign extUnsA      = {{WIDTH{1'b0}}, data1};
  assign extUnsB      = {{WIDTH{1'b0}}, data2};
  assign prodSigned   = extSignedA * extSignedB;
  assign prodUnsigned = extUnsA * extUnsB;
  assign hiLo         = {hi_q, lo_q};

  // Signed divide on magnitudes; most-negative / -1 falls out as quotient 0x80..0, remainder 0.
  always_comb begin
    negA    = data1[WIDTH-1];
    negB    = data2[WIDTH-1];
    divZero = (data2 == '0);
    magA    = negA ? -data1 : data1;
    magB    = negB ? -data2 : data2;
    magQuot = divZero ? '0 : magA / magB;
    magRem  = divZero ? '0 : magA % magB;
    sQuot   = (negA ^ negB) ? -magQuot : magQuot;
    sRem    = negA ? -magRem : magRem;
    uQuot   = divZero ? '0 : data1 / data2;
    uRem    = divZero ? '0 : data1 % data2;
  end

  always_comb begin
    isMulOp  = (mdu_op_e == OP_MULT) || (mdu_op_e == OP_MULTU) ||
               ((mdu_op_e >= OP_MADD) && (mdu_op_e <= OP_MSUBU));
    isDivOp  = (mdu_op_e == OP_DIV) || (mdu_op_e == OP_DIVU);
    isStartE = isMulOp || isDivOp;
    isMduD   = (mdu_op_d != 4'd0) && (mdu_op_d <= OP_MSUBU);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    case (state_q)
      IDLE: begin
        case (mdu_op_e)
          OP_MULT:  {pendHi_d, pendLo_d} = prodSigned;
          OP_MULTU: {pendHi_d, pendLo_d} = prodUnsigned;
          OP_MADD:  {pendHi_d, pendLo_d} = hiLo + prodSigned;
          OP_MADDU: {pendHi_d, pendLo_d} = hiLo + prodUnsigned;
          OP_MSUB:  {pendHi_d, pendLo_d} = hiLo - prodSigned;
          OP_MSUBU: {pendHi_d, pendLo_d} = hiLo - prodUnsigned;
          OP_DIV:   {pendHi_d, pendLo_d} = divZero ? hiLo : {sRem, sQuot};
          OP_DIVU:  {pendHi_d, pendLo_d} = divZero ? hiLo : {uRem, uQuot};
          OP_MTHI:  hi_d = data1;
          OP_MTLO:  lo_d = data1;
          default:  ;
        endcase
        if (isMulOp) begin
          cnt_d   = MUL_LOAD;
          state_d = BUSY;
        end else if (isDivOp) begin
          cnt_d   = DIV_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The edge that would take the counter to zero is the commit edge.
        if (cnt_q <= CW'(1)) begin
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == BUSY);
    stall_mdu = isMduD && (busy || isStartE);
    case (mdu_op_e)
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: a directed vector table, hand-written corner sequences and random ops
// on a 32-bit/5/10 instance and a 16-bit/1/17 instance, checked against a plain-arithmetic model.
module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opD, opE, opD16, opE16;
  logic [31:0] d1, d2, out32;
  logic [15:0] d1s, d2s, out16;
  logic        busy32, stall32, busy16, stall16;

  int total = 0;
  int bad   = 0;
  longint unsigned pair32, pair16;

  always #5 clk = ~clk;

  mdu_multicycle #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .mdu_op_d(opD), .mdu_op_e(opE),
    .data1(d1), .data2(d2), .out(out32), .busy(busy32), .stall_mdu(stall32)
  );

  mdu_multicycle #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(17)) dut16 (
    .clk(clk), .reset(reset), .mdu_op_d(opD16), .mdu_op_e(opE16),
    .data1(d1s), .data2(d2s), .out(out16), .busy(busy16), .stall_mdu(stall16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expLen;
  } vec_t;

  vec_t vecs[10];

  function automatic longint unsigned mask1(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned maskPair(int w);
    return (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic longint sx(longint unsigned v, int w);
    longint unsigned m = mask1(w);
    v = v & m;
    if (((v >> (w - 1)) & 64'd1) != 64'd0) return $signed(v) - $signed(64'd1 << w);
    return $signed(v);
  endfunction

  // HI/LO as one 2W-bit number; every rule is plain integer arithmetic reduced mod 2^(2W).
  function automatic longint unsigned refModel(int op, longint unsigned a, longint unsigned b,
                                               longint unsigned pair, int w);
    longint unsigned m = mask1(w);
    longint unsigned res = pair;
    longint sa = sx(a, w);
    longint sb = sx(b, w);
    longint q, r;
    a = a & m;
    b = b & m;
    case (op)
      1:  res = $unsigned(sa * sb);
      2:  res = a * b;
      3:  if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            res = (($unsigned(r) & m) << w) | ($unsigned(q) & m);
          end
      4:  if (b != 0) res = (((a % b) & m) << w) | ((a / b) & m);
      7:  res = (a << w) | (pair & m);
      8:  res = ((pair >> w) << w) | a;
      9:  res = pair + $unsigned(sa * sb);
      10: res = pair + a * b;
      11: res = pair - $unsigned(sa * sb);
      12: res = pair - a * b;
      default: ;
    endcase
    return res & maskPair(w);
  endfunction

  function automatic int lenFor(int which, int op);
    if (op == 1 || op == 2 || (op >= 9 && op <= 12)) return (which == 0) ? 5 : 1;
    if (op == 3 || op == 4) return (which == 0) ? 10 : 17;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    if (which == 0) begin
      opE = op; d1 = a; d2 = b;
    end else begin
      opE16 = op; d1s = a[15:0]; d2s = b[15:0];
    end
  endtask

  // Issue one op (sampled at the next edge), update the model, and count busy cycles.
  task automatic runOp(input int which, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int len);
    applyStimulus(which, op, a, b);
    @(negedge clk);
    applyStimulus(which, 4'd0, a, b);
    if (which == 0) pair32 = refModel(int'(op), a, b, pair32, 32);
    else            pair16 = refModel(int'(op), a, b, pair16, 16);
    len = 0;
    while (((which == 0) ? busy32 : busy16) && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic readHiLo(input int which, input logic [31:0] expHi, input logic [31:0] expLo,
                          input string tag);
    if (which == 0) begin
      opE = 4'd5; #1; checkOutput({tag, "_hi"}, 64'(out32), 64'(expHi));
      opE = 4'd6; #1; checkOutput({tag, "_lo"}, 64'(out32), 64'(expLo));
      opE = 4'd0; #1;
    end else begin
      opE16 = 4'd5; #1; checkOutput({tag, "_hi16"}, 64'(out16), 64'(expHi[15:0]));
      opE16 = 4'd6; #1; checkOutput({tag, "_lo16"}, 64'(out16), 64'(expLo[15:0]));
      opE16 = 4'd0; #1;
    end
  endtask

  task automatic readModel(input int which, input string tag);
    if (which == 0) readHiLo(0, pair32[63:32], pair32[31:0], tag);
    else            readHiLo(1, 32'(pair16[31:16]), 32'(pair16[15:0]), tag);
  endtask

  initial begin
    logic [3:0]  opList[10];
    logic [31:0] a, b;
    logic [3:0]  op;
    int          len, sel;

    opList = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    vecs[0] = '{4'd1,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{4'd4,  32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[2] = '{4'd3,  32'd5,         32'd0,         32'd2,         32'd14,        10};
    vecs[3] = '{4'd8,  32'd5,         32'd0,         32'd2,         32'd5,         0};
    vecs[4] = '{4'd7,  32'd0,         32'd0,         32'd0,         32'd5,         0};
    vecs[5] = '{4'd10, 32'hFFFF_FFFF, 32'd2,         32'd2,         32'd3,         5};
    vecs[6] = '{4'd11, 32'd1,         32'd4,         32'd1,         32'hFFFF_FFFF, 5};
    vecs[7] = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[8] = '{4'd3,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[9] = '{4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};

    reset = 1'b1;
    opD = 4'd0; opD16 = 4'd0;
    applyStimulus(0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1, 4'd0, 32'd0, 32'd0);
    pair32 = 0; pair16 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_busy", 64'({busy32, busy16}), 64'd0);
    checkOutput("reset_stall", 64'({stall32, stall16}), 64'd0);
    readHiLo(0, 32'd0, 32'd0, "reset");
    readHiLo(1, 32'd0, 32'd0, "reset");
    @(negedge clk);

    // Directed table, issued back-to-back in the cycle busy falls.
    for (int i = 0; i < 10; i++) begin
      runOp(0, vecs[i].op, vecs[i].a, vecs[i].b, len);
      checkOutput($sformatf("vec%0d_len", i), 64'(len), 64'(vecs[i].expLen));
      readHiLo(0, vecs[i].expHi, vecs[i].expLo, $sformatf("vec%0d", i));
    end

    // mflo waiting in D behind a mult; an mthi slipped into E mid-flight must be ignored.
    @(negedge clk);
    opD = 4'd6;
    applyStimulus(0, 4'd1, 32'd7, 32'd9);
    #1 checkOutput("stall_issue", 64'(stall32), 64'd1);
    @(negedge clk);
    applyStimulus(0, 4'd0, 32'd0, 32'd0);
    pair32 = refModel(1, 32'd7, 32'd9, pair32, 32);
    for (int i = 1; i <= 5; i++) begin
      #1 checkOutput($sformatf("stall_busy%0d", i), 64'({busy32, stall32}), 64'd3);
      if (i == 2) applyStimulus(0, 4'd7, 32'hDEAD, 32'd0);
      if (i == 3) applyStimulus(0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    #1 checkOutput("stall_after", 64'({busy32, stall32}), 64'd0);
    opD = 4'd0;
    readHiLo(0, 32'd0, 32'd63, "ignored_mthi");

    @(negedge clk);
    opD = 4'd1; opE = 4'd3;
    #1 checkOutput("stall_idle_div", 64'(stall32), 64'd1);
    opD = 4'd0;
    #1 checkOutput("stall_no_d", 64'(stall32), 64'd0);
    opD = 4'd13;
    #1 checkOutput("stall_d13", 64'(stall32), 64'd0);
    opD = 4'd0; opE = 4'd13;
    #1 checkOutput("out_none", 64'(out32), 64'd0);
    opE = 4'd0;

    // Reset during busy cycle 3 of an overflowing divide.
    @(negedge clk);
    applyStimulus(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("rst_mid_busy_before", 64'(busy32), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pair32 = 0; pair16 = 0;
    #1 checkOutput("rst_mid_busy", 64'(busy32), 64'd0);
    readHiLo(0, 32'd0, 32'd0, "rst_mid");
    @(negedge clk);
    runOp(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, len);
    checkOutput("ovf_len", 64'(len), 64'd10);
    readHiLo(0, 32'd0, 32'h8000_0000, "ovf");

    // Start op and reset in the same cycle: reset wins.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 4'd1, 32'd5, 32'd5);
    @(negedge clk);
    applyStimulus(0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;
    pair32 = 0; pair16 = 0;
    #1 checkOutput("rst_start_busy", 64'(busy32), 64'd0);
    readHiLo(0, 32'd0, 32'd0, "rst_start");

    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      op = opList[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      runOp(0, op, a, b, len);
      checkOutput($sformatf("rnd32_%0d_op%0d_len", i, op), 64'(len), 64'(lenFor(0, int'(op))));
      readModel(0, $sformatf("rnd32_%0d", i));
    end

    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      op = (i < 10) ? opList[i] : opList[$urandom_range(0, 9)];
      a = 32'($urandom_range(0, 65535));
      b = 32'($urandom_range(0, 65535));
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000; b = 32'hFFFF; end
      runOp(1, op, a, b, len);
      checkOutput($sformatf("rnd16_%0d_op%0d_len", i, op), 64'(len), 64'(lenFor(1, int'(op))));
      readModel(1, $sformatf("rnd16_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
